spi_byte_tx: RTL and testbench

//  Write-only SPI master (mode 0, MSB first) for the OLED driver path.

---
 rtl/spi_byte_tx.sv | 123 ++++++++++++
 tb/tb_spi_byte_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_tx.sv
// Write-only SPI master, mode 0 (sclk idles low, receiver samples on rising
// edges), MSB first. It accepts one byte per handshake and shifts it out on
// sclk/sdo. Chip select lives outside this block (cs_n = ~en).
//
// Handshake: rdy=1 means the block is idle and can take a byte. In IDLE, a
// posedge with en=1 captures data and drops rdy on that same edge. en and
// data are ignored for the rest of the transfer. After the last bit, rdy goes
// high for one DONE cycle, and en is not sampled there. That cycle gives the
// producer time to present the next byte before the next IDLE capture.
//
// Debug: the FSM register (state) and the bit pointer (idx) are plain named
// signals so a bench can probe them hierarchically.

module spi_byte_tx #(
  parameter int N     = 4,  // clk cycles per sclk half-period, >= 1
  parameter int WIDTH = 8   // bits per transfer
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic             rdy,
  output logic             sclk,
  output logic             sdo
);

  // The half-period counter counts 0..N-1. The extra bit keeps N=1 legal.
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

  // The bit pointer must be able to address every bit of the shift register.
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;

  // A phase ends when the counter has spent N cycles in it.
  logic phase_end;
  assign phase_end = (cnt == CNT_MAX);

  // Sequencer: it owns the state, the counters and every output register.
  // sdo only changes when sclk falls, or on the accepting edge while sclk is
  // already low, so each bit is stable around its rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdy   <= 1'b1;
      sclk  <= 1'b0;
      sdo   <= 1'b0;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt  <= '0;
          sclk <= 1'b0;
          if (en) begin
            shreg <= data;
            idx   <= IDX_TOP;
            sdo   <= data[WIDTH-1];
            rdy   <= 1'b0;
            state <= LOW;
          end else begin
            sdo <= 1'b0;
            rdy <= 1'b1;
          end
        end

        LOW: begin
          if (phase_end) begin
            cnt   <= '0;
            sclk  <= 1'b1;
            state <= HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HIGH: begin
          if (phase_end) begin
            cnt  <= '0;
            sclk <= 1'b0;
            if (idx != '0) begin
              idx   <= idx - 1'b1;
              sdo   <= shreg[idx - 1'b1];
              state <= LOW;
            end else begin
              sdo   <= 1'b0;
              rdy   <= 1'b1;
              state <= DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          // This cycle is spent deliberately with rdy high and en ignored.
          cnt   <= '0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          rdy   <= 1'b1;
          sclk  <= 1'b0;
          sdo   <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_tx.sv
// Directed bench for spi_byte_tx. There are two instances: N=4 (dut4) and
// N=1 (dut1). Inputs change on negedge and outputs are sampled on negedge.

module tb_spi_byte_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en4, en1;
  logic [7:0] data4, data1;
  logic       rdy4, sclk4, sdo4;
  logic       rdy1, sclk1, sdo1;

  spi_byte_tx #(.N(4), .WIDTH(8)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .data(data4),
    .rdy(rdy4), .sclk(sclk4), .sdo(sdo4)
  );

  spi_byte_tx #(.N(1), .WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .data(data1),
    .rdy(rdy1), .sclk(sclk1), .sdo(sdo1)
  );

  localparam logic [1:0] ST_IDLE = 2'd0;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver / monitor ----------------
  // This task is called on the negedge where rdy was first seen low. It
  // follows the transfer until rdy rises. Along the way it records sdo at
  // each sclk rise, counts the rdy-low samples, measures every sclk phase
  // length, and flags any sdo change while sclk is high. If drop_rise > 0,
  // en is dropped and data is scrambled right after that many rises.
  task automatic run_byte(input bit sel, input int drop_rise,
                          output logic [7:0] got, output int low_cyc,
                          output int bad_phase, output int bad_hold,
                          output int rises, output bit timeout);
    int n_half;
    int run;
    int cyc;
    logic prev_s;
    logic held;
    n_half = sel ? 1 : 4;
    got = 8'h00; low_cyc = 1; bad_phase = 0; bad_hold = 0; rises = 0;
    timeout = 1'b0; cyc = 0; run = 1; held = 1'b0;
    prev_s = sel ? sclk1 : sclk4;
    if (prev_s !== 1'b0) bad_phase++;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 2000) begin
        timeout = 1'b1;
        break;
      end
      if ((sel ? rdy1 : rdy4) === 1'b1) begin
        if (run != n_half) bad_phase++;
        break;
      end
      low_cyc++;
      if ((sel ? sclk1 : sclk4) !== prev_s) begin
        if (run != n_half) bad_phase++;
        run = 1;
        if ((sel ? sclk1 : sclk4) === 1'b1) begin
          held = sel ? sdo1 : sdo4;
          got = {got[6:0], held};
          rises++;
          if (rises == drop_rise) begin
            if (sel) begin en1 = 1'b0; data1 = 8'h00; end
            else begin en4 = 1'b0; data4 = 8'h00; end
          end
        end
      end else begin
        run++;
        if (prev_s === 1'b1 && (sel ? sdo1 : sdo4) !== held) bad_hold++;
      end
      prev_s = sel ? sclk1 : sclk4;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] got;
    int low_cyc, bad_phase, bad_hold, rises, act;
    bit to;

    rst = 1'b1; en4 = 1'b0; en1 = 1'b0; data4 = 8'h00; data1 = 8'h00;

    // 1: reset for two cycles, then stay quiet while en=0
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rdy", {31'd0, rdy4}, 32'd1);
    chk("reset_sclk", {31'd0, sclk4}, 32'd0);
    chk("reset_sdo", {31'd0, sdo4}, 32'd0);
    chk("reset_state", {30'd0, dut4.state}, {30'd0, ST_IDLE});
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (sclk4 !== 1'b0 || rdy4 !== 1'b1 || sclk1 !== 1'b0) act++;
    end
    chk("idle_no_activity", act, 0);

    // 2: A5 at N=4
    data4 = 8'hA5; en4 = 1'b1;
    @(negedge clk);
    chk("a5_rdy_drop", {31'd0, rdy4}, 32'd0);
    run_byte(1'b0, 0, got, low_cyc, bad_phase, bad_hold, rises, to);
    chk("a5_timeout", {31'd0, to}, 32'd0);
    chk("a5_bits", {24'd0, got}, 32'h0000_00A5);
    chk("a5_rises", rises, 8);
    chk("a5_rdy_low", low_cyc, 64);
    chk("a5_phase_len", bad_phase, 0);
    chk("a5_sdo_hold", bad_hold, 0);
    chk("a5_done_sclk", {31'd0, sclk4}, 32'd0);

    // 3: en held high; the producer loads 3C in the DONE cycle
    data4 = 8'h3C;
    @(negedge clk);
    chk("b2b_idle_rdy", {31'd0, rdy4}, 32'd1);
    @(negedge clk);
    chk("b2b_rdy_fall", {31'd0, rdy4}, 32'd0);
    run_byte(1'b0, 0, got, low_cyc, bad_phase, bad_hold, rises, to);
    chk("3c_timeout", {31'd0, to}, 32'd0);
    chk("3c_bits", {24'd0, got}, 32'h0000_003C);
    chk("3c_rdy_low", low_cyc, 64);
    chk("3c_phase_len", bad_phase, 0);

    // 4: FF with en dropped (and data scrambled) mid-byte
    data4 = 8'hFF;
    repeat (2) @(negedge clk);
    chk("ff_rdy_fall", {31'd0, rdy4}, 32'd0);
    run_byte(1'b0, 5, got, low_cyc, bad_phase, bad_hold, rises, to);
    chk("ff_timeout", {31'd0, to}, 32'd0);
    chk("ff_bits", {24'd0, got}, 32'h0000_00FF);
    chk("ff_rises", rises, 8);
    chk("ff_rdy_low", low_cyc, 64);
    act = 0;
    repeat (12) begin
      @(negedge clk);
      if (rdy4 !== 1'b1 || sclk4 !== 1'b0) act++;
    end
    chk("ff_no_restart", act, 0);

    // 5: reset in the middle of the HIGH phase of bit 5 of C3
    data4 = 8'hC3; en4 = 1'b1;
    @(negedge clk);
    en4 = 1'b0;
    rises = 0; act = 0;
    while (rises < 3 && act < 500) begin
      logic p;
      p = sclk4;
      @(negedge clk);
      act++;
      if (p === 1'b0 && sclk4 === 1'b1) rises++;
    end
    chk("abort_reach_bit5", rises, 3);
    @(negedge clk);
    chk("abort_mid_high", {31'd0, sclk4}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_sclk", {31'd0, sclk4}, 32'd0);
    chk("abort_sdo", {31'd0, sdo4}, 32'd0);
    chk("abort_rdy", {31'd0, rdy4}, 32'd1);
    chk("abort_state", {30'd0, dut4.state}, {30'd0, ST_IDLE});
    data4 = 8'h81; en4 = 1'b1;
    @(negedge clk);
    en4 = 1'b0;
    chk("81_rdy_drop", {31'd0, rdy4}, 32'd0);
    run_byte(1'b0, 0, got, low_cyc, bad_phase, bad_hold, rises, to);
    chk("81_timeout", {31'd0, to}, 32'd0);
    chk("81_bits", {24'd0, got}, 32'h0000_0081);
    chk("81_rdy_low", low_cyc, 64);

    // 6: N=1, data 01
    data1 = 8'h01; en1 = 1'b1;
    @(negedge clk);
    en1 = 1'b0;
    chk("n1_rdy_drop", {31'd0, rdy1}, 32'd0);
    run_byte(1'b1, 0, got, low_cyc, bad_phase, bad_hold, rises, to);
    chk("n1_timeout", {31'd0, to}, 32'd0);
    chk("n1_bits", {24'd0, got}, 32'h0000_0001);
    chk("n1_rises", rises, 8);
    chk("n1_rdy_low", low_cyc, 16);
    chk("n1_phase_len", bad_phase, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
